// File: rtl/amstrad_boot_pkg.sv
// Shared types and tables for the ROM boot sequencer and the MF2 ROM address path.
package amstrad_boot_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} boot_state_t;

  localparam int SLOT_BITS = 3;

  // SDRAM ROM region base (mem_addr[22:14]) indexed by slot[1:0].
  localparam logic [3:0][8:0] ROM_REGION = {9'h1ff, 9'h107, 9'h100, 9'h000};

endpackage

// File: rtl/boot_slot_map.sv
// Combinational decode of a linear 16 KB-slot byte address into the SDRAM ROM layout.
module boot_slot_map
  import amstrad_boot_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic [24:0]          addr,
  output logic [22:0]          mem_addr,
  output logic                 mem_bank,
  output logic [SLOT_BITS-1:0] slot,
  output logic                 valid
);

  logic [10:0] s;

  assign s        = addr[24:14];
  assign valid    = s < 11'(NUM_SLOTS);
  assign slot     = s[SLOT_BITS-1:0];
  assign mem_bank = s[2];
  assign mem_addr = {ROM_REGION[s[1:0]], addr[13:0]};

endmodule

// File: rtl/rom_boot_sequencer.sv
// Streams ioctl ROM bytes into SDRAM through a one-entry holding register and
// keeps the machine in reset until the image is committed plus a settle delay.
module rom_boot_sequencer
  import amstrad_boot_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX   = 8'd0,
  parameter int         HOLD_CYCLES = 64,
  parameter int         NUM_SLOTS   = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clkref,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic        mem_bank,
  output logic [7:0]  mem_din,
  output logic        cpu_reset_hold,
  output logic [7:0]  slot_loaded,
  output logic        drop_err,
  output logic [7:0]  checksum
);

  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  boot_state_t          state_q, state_d;
  logic                 dl_q, dl_d;
  logic                 full_q, full_d;
  logic [22:0]          addr_q, addr_d;
  logic                 bank_q, bank_d;
  logic [7:0]           din_q, din_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [7:0]           loaded_q, loaded_d;
  logic                 drop_q, drop_d;
  logic [7:0]           sum_q, sum_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [22:0]          map_addr;
  logic                 map_bank;
  logic [SLOT_BITS-1:0] map_slot;
  logic                 map_valid;
  logic                 start, fall;

  boot_slot_map #(.NUM_SLOTS(NUM_SLOTS)) u_map (
    .addr     (ioctl_addr),
    .mem_addr (map_addr),
    .mem_bank (map_bank),
    .slot     (map_slot),
    .valid    (map_valid)
  );

  assign start = ioctl_download & ~dl_q & (ioctl_index == ROM_INDEX);
  assign fall  = ~ioctl_download & dl_q;

  always_comb begin
    state_d  = state_q;
    dl_d     = ioctl_download;
    full_d   = full_q;
    addr_d   = addr_q;
    bank_d   = bank_q;
    din_d    = din_q;
    slot_d   = slot_q;
    loaded_d = loaded_q;
    drop_d   = drop_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;

    if (full_q && clkref) begin
      full_d           = 1'b0;
      sum_d            = sum_q + din_q;
      loaded_d[slot_q] = 1'b1;
    end

    // A strobe while full violates ioctl_wait; it is dropped like a bad address.
    if (state_q == LOAD && ioctl_wr) begin
      if (full_q || !map_valid) begin
        drop_d = 1'b1;
      end else begin
        full_d = 1'b1;
        addr_d = map_addr;
        bank_d = map_bank;
        din_d  = ioctl_dout;
        slot_d = map_slot;
      end
    end

    case (state_q)
      IDLE, HOLD: begin
        if (start) begin
          state_d  = LOAD;
          loaded_d = '0;
          drop_d   = 1'b0;
          sum_d    = '0;
        end else if (state_q == HOLD) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      LOAD: if (fall) state_d = DRAIN;
      DRAIN: begin
        if (!full_q) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      dl_q     <= 1'b0;
      full_q   <= 1'b0;
      addr_q   <= '0;
      bank_q   <= 1'b0;
      din_q    <= '0;
      slot_q   <= '0;
      loaded_q <= '0;
      drop_q   <= 1'b0;
      sum_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dl_q     <= dl_d;
      full_q   <= full_d;
      addr_q   <= addr_d;
      bank_q   <= bank_d;
      din_q    <= din_d;
      slot_q   <= slot_d;
      loaded_q <= loaded_d;
      drop_q   <= drop_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
    end
  end

  // Gate with reset so a pending write is withdrawn in the cycle reset is seen.
  assign mem_we         = full_q & ~reset;
  assign ioctl_wait     = full_q;
  assign mem_addr       = addr_q;
  assign mem_bank       = bank_q;
  assign mem_din        = din_q;
  assign cpu_reset_hold = (state_q != IDLE);
  assign slot_loaded    = loaded_q;
  assign drop_err       = drop_q;
  assign checksum       = sum_q;

endmodule

// File: tb/tb_rom_boot_sequencer.sv
// Directed self-checking bench for rom_boot_sequencer.
module tb_rom_boot_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        clkref = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait, mem_we, mem_bank, cpu_reset_hold, drop_err;
  logic [22:0] mem_addr;
  logic [7:0]  mem_din, slot_loaded, checksum;

  int checks = 0;
  int failures = 0;
  int we_cycles = 0;

  rom_boot_sequencer #(.ROM_INDEX(8'd0), .HOLD_CYCLES(64), .NUM_SLOTS(8)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .clkref         (clkref),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_bank       (mem_bank),
    .mem_din        (mem_din),
    .cpu_reset_hold (cpu_reset_hold),
    .slot_loaded    (slot_loaded),
    .drop_err       (drop_err),
    .checksum       (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (mem_we) we_cycles++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_sys);
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  // n idle cycles without clkref, then one cycle with clkref.
  task automatic commit_after(input int n);
    repeat (n) tick();
    clkref = 1'b1;
    tick();
    clkref = 1'b0;
  endtask

  initial begin
    int base, n, bad;

    tick(); tick();
    smp();
    chk("rst_we", mem_we, 0);
    chk("rst_hold", cpu_reset_hold, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_outs", {mem_addr, mem_bank, mem_din, slot_loaded, drop_err, checksum}, 0);
    reset = 1'b0;
    tick();

    // Session 1
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    smp();
    chk("s1_hold", cpu_reset_hold, 1);
    chk("s1_we_idle", mem_we, 0);

    base = we_cycles;
    wr_byte(25'h00000, 8'hA5);
    smp();
    chk("t1_we", mem_we, 1);
    chk("t1_wait", ioctl_wait, 1);
    chk("t1_addr", {mem_bank, mem_addr}, 24'h000000);
    chk("t1_din", mem_din, 8'hA5);
    commit_after(5);
    chk("t1_we_len", we_cycles - base, 6);
    smp();
    chk("t1_we_off", mem_we, 0);
    chk("t1_sum", checksum, 8'hA5);
    chk("t1_slots", slot_loaded, 8'h01);

    wr_byte(25'h0C123, 8'h80);
    smp();
    chk("t2_slot3", {mem_bank, mem_addr}, 24'h7FC123);
    base = we_cycles;
    commit_after(0);
    chk("t2_we_min", we_cycles - base, 1);
    wr_byte(25'h1C123, 8'h90);
    smp();
    chk("t2_slot7", {mem_bank, mem_addr}, {1'b1, 23'h7FC123});
    commit_after(2);
    smp();
    // slot 0 from the first byte is still set in this session; A5+80+90 wraps
    chk("t2_slots", slot_loaded, 8'h89);
    chk("t2_sum", checksum, 8'hB5);
    chk("t2_drop", drop_err, 0);

    base = we_cycles;
    wr_byte(25'h20000, 8'h55);
    tick(); tick();
    smp();
    chk("t3_no_we", we_cycles - base, 0);
    chk("t3_drop", drop_err, 1);
    chk("t3_sum", checksum, 8'hB5);
    chk("t3_slots", slot_loaded, 8'h89);

    // End session 1, then restart from HOLD
    ioctl_download = 1'b0;
    repeat (7) tick();
    smp();
    chk("s1_in_hold", cpu_reset_hold, 1);
    ioctl_download = 1'b1;
    tick();
    smp();
    chk("s2_clear", {slot_loaded, drop_err, checksum}, 0);
    chk("s2_hold", cpu_reset_hold, 1);

    // Back-to-back strobes with no clkref
    wr_byte(25'h04000, 8'h33);
    wr_byte(25'h08000, 8'h44);
    smp();
    chk("t4_wait", ioctl_wait, 1);
    chk("t4_drop", drop_err, 1);
    chk("t4_keep", {mem_bank, mem_addr, mem_din}, {1'b0, 23'h400000, 8'h33});

    // Download ends with the byte still pending
    ioctl_download = 1'b0;
    tick();
    smp();
    chk("t5_pend", {cpu_reset_hold, mem_we}, 2'b11);
    commit_after(3);
    smp();
    n = 0;
    while (cpu_reset_hold && n < 200) begin
      n++;
      smp();
    end
    // one DRAIN cycle after the commit, then 64 HOLD cycles
    chk("t5_hold_len", n, 65);
    bad = 0;
    repeat (20) begin
      smp();
      if (cpu_reset_hold) bad++;
    end
    chk("t5_hold_once", bad, 0);
    chk("t5_sum", checksum, 8'h33);
    chk("t5_slots", slot_loaded, 8'h02);

    // Non-ROM index download
    tick();
    base = we_cycles;
    bad = 0;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      clkref = i[0];
      wr_byte(25'(i * 97), 8'(i));
      smp();
      if (cpu_reset_hold) bad++;
    end
    clkref = 1'b0;
    ioctl_download = 1'b0;
    tick();
    chk("t6_no_we", we_cycles - base, 0);
    chk("t6_no_hold", bad, 0);
    chk("t6_outs", {slot_loaded, drop_err, checksum}, {8'h02, 1'b1, 8'h33});

    // Synchronous reset while a write is pending
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    wr_byte(25'h00100, 8'h77);
    smp();
    chk("t7_we", mem_we, 1);
    tick();
    reset = 1'b1;
    ioctl_download = 1'b0;
    #1;
    chk("t7_we_same", mem_we, 0);
    tick();
    reset = 1'b0;
    smp();
    chk("t7_we_after", mem_we, 0);
    chk("t7_state", {cpu_reset_hold, ioctl_wait, checksum, slot_loaded}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
